// File: rtl/execute_stage_if.sv
// execute_stage_if: E-register inputs, forwarding outputs and M-register outputs of the execute stage
interface execute_stage_if;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic [3:0]  e_rA;
    logic [3:0]  e_rB;
    logic [63:0] e_valC;
    logic [63:0] e_valA;
    logic [63:0] e_valB;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic        M_bubble;
    logic        e_Cnd;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [2:0]  cc_out;
    modport master (
        output e_stat, e_icode, e_ifun, e_rA, e_rB, e_valC, e_valA, e_valB, m_stat, W_stat, M_bubble,
        input  e_Cnd, e_valE, e_dstE, M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc_out
    );
    modport slave (
        input  e_stat, e_icode, e_ifun, e_rA, e_rB, e_valC, e_valA, e_valB, m_stat, W_stat, M_bubble,
        output e_Cnd, e_valE, e_dstE, M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc_out
    );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: Y86-64 ALU, condition codes, branch/cmov condition and M pipeline register
module execute_stage (
    input  logic           clk,
    input  logic           rst_n,
    execute_stage_if.slave bus
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [2:0] SAOK  = 3'd1;
    localparam logic [2:0] SHLT  = 3'd2;
    localparam logic [2:0] SADR  = 3'd3;
    localparam logic [2:0] SINS  = 3'd4;
    logic [3:0]  ic;
    logic [63:0] alu_a, alu_b, t;
    logic [3:0]  alufun, dst_m;
    logic        zf, sf, of, n_zf, n_sf, n_of, set_cc, cnd;
    assign ic = bus.e_icode;
    always_comb begin
        alu_a = (ic inside {4'h2, 4'h6})       ? bus.e_valA :
                (ic inside {4'h3, 4'h4, 4'h5}) ? bus.e_valC :
                (ic inside {4'h8, 4'hA})       ? 64'hFFFF_FFFF_FFFF_FFF8 :
                (ic inside {4'h9, 4'hB})       ? 64'd8 : 64'd0;
        alu_b = (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? bus.e_valB : 64'd0;
        alufun = (ic == 4'h6) ? bus.e_ifun : 4'h0;
        t = (alufun == 4'h0) ? alu_b + alu_a :
            (alufun == 4'h1) ? alu_b - alu_a :
            (alufun == 4'h2) ? alu_b & alu_a :
            (alufun == 4'h3) ? alu_b ^ alu_a : 64'd0;
        n_zf = (t == 64'd0);
        n_sf = t[63];
        n_of = (alufun == 4'h0) ? (alu_a[63] == alu_b[63]) && (t[63] != alu_a[63]) :
               (alufun == 4'h1) ? (alu_a[63] != alu_b[63]) && (t[63] != alu_b[63]) : 1'b0;
        set_cc = (ic == 4'h6) && !(bus.m_stat inside {SADR, SINS, SHLT})
                              && !(bus.W_stat inside {SADR, SINS, SHLT});
    end
    // Condition uses the CC as it stands before this instruction's own update
    always_comb begin
        case (bus.e_ifun)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = (sf ^ of) | zf;
            4'h2:    cnd = sf ^ of;
            4'h3:    cnd = zf;
            4'h4:    cnd = !zf;
            4'h5:    cnd = !(sf ^ of);
            4'h6:    cnd = !(sf ^ of) & !zf;
            default: cnd = 1'b0;
        endcase
    end
    assign dst_m      = (ic inside {4'h5, 4'hB}) ? bus.e_rA : RNONE;
    assign bus.e_Cnd  = cnd;
    assign bus.e_valE = t;
    assign bus.e_dstE = (ic == 4'h2 && !cnd)           ? RNONE :
                        (ic inside {4'h2, 4'h3, 4'h6}) ? bus.e_rB :
                        (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RRSP : RNONE;
    assign bus.cc_out = {zf, sf, of};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {zf, sf, of} <= 3'b100;
            bus.M_stat   <= SAOK;
            bus.M_icode  <= 4'h1;
            bus.M_Cnd    <= 1'b0;
            bus.M_valE   <= 64'd0;
            bus.M_valA   <= 64'd0;
            bus.M_dstE   <= RNONE;
            bus.M_dstM   <= RNONE;
        end else begin
            if (set_cc) {zf, sf, of} <= {n_zf, n_sf, n_of};
            bus.M_stat  <= bus.M_bubble ? SAOK   : bus.e_stat;
            bus.M_icode <= bus.M_bubble ? 4'h1   : ic;
            bus.M_Cnd   <= bus.M_bubble ? 1'b0   : cnd;
            bus.M_valE  <= bus.M_bubble ? 64'd0  : t;
            bus.M_valA  <= bus.M_bubble ? 64'd0  : bus.e_valA;
            bus.M_dstE  <= bus.M_bubble ? RNONE  : bus.e_dstE;
            bus.M_dstM  <= bus.M_bubble ? RNONE  : dst_m;
        end
    end
endmodule
